// File: rtl/conv_pkg.sv
// Shared definitions between the column feeder and the 3x3 convolution engine:
// pixel width, stream width and the byte lanes of a packed vertical column.
package conv_pkg;

   localparam int PIXEL_NB           = 8;
   localparam int C_AXIS_TDATA_WIDTH = 32;

   // Column word layout: oldest row in the low lane, current row on top.
   localparam int ROW_M2_LSB  = 0;
   localparam int ROW_M1_LSB  = 8;
   localparam int ROW_CUR_LSB = 16;

   // Row counter saturates here once two full history rows are buffered.
   localparam logic [1:0] ROW_PRIMED = 2'd2;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixels: register array with synchronous write and
// combinational read, both at the same column address.
module conv_line_buffer #(
   parameter int DEPTH      = 640,
   parameter int ADDR_WIDTH = 12,
   parameter int PIXEL_NB   = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [PIXEL_NB-1:0]   wdata,
   output logic [PIXEL_NB-1:0]   rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PIXEL_NB-1:0] mem [DEPTH];
   logic [IDX_W-1:0]    idx;

   assign idx = addr[IDX_W-1:0];

   // Upper address bits are always zero because the column counter wraps below DEPTH.
   generate
      if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IDX_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/conv_column_feeder.sv
// AXI-Stream front end for the 3x3 convolution engine: turns a raster pixel
// stream into one packed vertical 3-pixel column per accepted pixel.
module conv_column_feeder #(
   parameter int C_AXIS_TDATA_WIDTH = conv_pkg::C_AXIS_TDATA_WIDTH,
   parameter int PIXEL_NB           = conv_pkg::PIXEL_NB,
   parameter int ADDR_WIDTH         = 12,
   parameter int IMG_WIDTH          = 640
) (
   input  logic                          axis_aclk,
   input  logic                          axis_areset,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                          s00_axis_tvalid,
   output logic                          s00_axis_tready,
   input  logic                          s00_axis_tlast,
   output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic                          m00_axis_tvalid,
   input  logic                          m00_axis_tready,
   output logic                          m00_axis_tlast,
   output logic                          frame_err
);

   import conv_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);

   logic [ADDR_WIDTH-1:0]         col;
   logic [1:0]                    row;
   logic                          accept;
   logic                          emit;
   logic                          row_end;
   logic                          bad_end;
   logic [PIXEL_NB-1:0]           pixel;
   logic [PIXEL_NB-1:0]           lb0_rd;
   logic [PIXEL_NB-1:0]           lb1_rd;
   logic [C_AXIS_TDATA_WIDTH-1:0] column;
   logic                          unused_tdata_hi;

   assign pixel           = s00_axis_tdata[PIXEL_NB-1:0];
   assign unused_tdata_hi = ^s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:PIXEL_NB];

   // Priming beats obey the same ready rule so a held output beat is never lost.
   assign s00_axis_tready = ~m00_axis_tvalid | m00_axis_tready;
   assign accept          = s00_axis_tvalid & s00_axis_tready;
   assign emit            = accept & (row == ROW_PRIMED);
   assign row_end         = (col == COL_LAST);
   assign bad_end         = ~row_end | (row != ROW_PRIMED);

   conv_line_buffer #(
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .PIXEL_NB   (PIXEL_NB)
   ) u_lb0 (
      .clk   (axis_aclk),
      .we    (accept),
      .addr  (col),
      .wdata (lb1_rd),
      .rdata (lb0_rd)
   );

   conv_line_buffer #(
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .PIXEL_NB   (PIXEL_NB)
   ) u_lb1 (
      .clk   (axis_aclk),
      .we    (accept),
      .addr  (col),
      .wdata (pixel),
      .rdata (lb1_rd)
   );

   // Column uses pre-write line-buffer values: rows r-2 and r-1 at this column.
   always_comb begin
      column                              = '0;
      column[ROW_M2_LSB  +: PIXEL_NB]     = lb0_rd;
      column[ROW_M1_LSB  +: PIXEL_NB]     = lb1_rd;
      column[ROW_CUR_LSB +: PIXEL_NB]     = pixel;
   end

   // Raster position and frame-end checking.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         col       <= '0;
         row       <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (accept) begin
            if (s00_axis_tlast) begin
               col       <= '0;
               row       <= '0;
               frame_err <= bad_end;
            end else if (row_end) begin
               col <= '0;
               if (row != ROW_PRIMED) begin
                  row <= row + 2'd1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Output register: load and drain may coincide for full throughput.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         m00_axis_tlast  <= 1'b0;
      end else if (emit) begin
         m00_axis_tvalid <= 1'b1;
         m00_axis_tdata  <= column;
         m00_axis_tlast  <= s00_axis_tlast;
      end else if (m00_axis_tready) begin
         m00_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_column_feeder.sv
// Directed bench for conv_column_feeder with a 4-pixel-wide image where each
// pixel value is 16*row + col.
module tb_conv_column_feeder;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        frame_err;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] out_data [$];
   logic        out_last [$];
   int          err_pulses;

   always #5 clk = ~clk;

   conv_column_feeder #(
      .C_AXIS_TDATA_WIDTH (32),
      .PIXEL_NB           (8),
      .ADDR_WIDTH         (12),
      .IMG_WIDTH          (W)
   ) dut (
      .axis_aclk       (clk),
      .axis_areset     (rst),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .s00_axis_tlast  (s_tlast),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tlast  (m_tlast),
      .frame_err       (frame_err)
   );

   // Output capture: a beat transfers at the edge following a negedge with valid & ready.
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready) begin
         out_data.push_back(m_tdata);
         out_last.push_back(m_tlast);
      end
      if (!rst && frame_err) err_pulses++;
   end

   function automatic logic [7:0] px(input int r, input int c);
      return 8'(16 * r + c);
   endfunction

   function automatic logic [31:0] exp_col(input int r, input int c);
      return {8'h00, px(r, c), px(r - 1, c), px(r - 2, c)};
   endfunction

   task automatic clear_capture();
      out_data.delete();
      out_last.delete();
      err_pulses = 0;
   endtask

   task automatic send_beat(input logic [7:0] p, input logic last);
      logic ok;
      s_tdata  = {24'h0, p};
      s_tvalid = 1'b1;
      s_tlast  = last;
      ok       = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL beat_accept: pixel %02h not accepted, got tready=%b want 1", p, s_tready);
      end
   endtask

   task automatic idle(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < W; c++)
            send_beat(px(r, c), (r == 3) && (c == W - 1));
   endtask

   task automatic check_frame(input string name, input int base);
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (base + k >= out_data.size()) begin
            miscompares++;
            $display("FAIL %s_missing[%0d]: got %0d outputs, want at least %0d", name, k, out_data.size(), base + k + 1);
         end else if (out_data[base + k] !== exp_col(2 + k / W, k % W) || out_last[base + k] !== (k == 7)) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %08h last=%b, want %08h last=%b", name, k,
                     out_data[base + k], out_last[base + k], exp_col(2 + k / W, k % W), (k == 7));
         end
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 32'h55;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({m_tvalid, m_tlast, frame_err} !== 3'b000 || m_tdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b last=%b err=%b data=%08h, want 0 0 0 00000000",
                  m_tvalid, m_tlast, frame_err, m_tdata);
      end
      s_tvalid = 1'b0;
      rst      = 1'b0;
      #1;
      vectors++;
      if (s_tready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_tready: got %b want 1", s_tready);
      end
      idle(1);
   endtask

   task automatic test_stream();
      int nlast;
      clear_capture();
      for (int k = 0; k < 2 * W; k++) send_beat(px(k / W, k % W), 1'b0);
      vectors++;
      if (out_data.size() != 0 || m_tvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL priming: got %0d outputs valid=%b, want 0 outputs valid=0", out_data.size(), m_tvalid);
      end
      for (int k = 2 * W; k < 4 * W; k++) send_beat(px(k / W, k % W), k == 4 * W - 1);
      idle(4);
      vectors++;
      if (out_data.size() != 8) begin
         miscompares++;
         $display("FAIL stream_count: got %0d want 8", out_data.size());
      end
      vectors++;
      if (out_data.size() < 1 || out_data[0] !== 32'h00201000) begin
         miscompares++;
         $display("FAIL stream_first: got %08h want 00201000", out_data.size() ? out_data[0] : 32'hx);
      end
      vectors++;
      if (out_data.size() < 8 || out_data[7] !== 32'h00332313 || out_last[7] !== 1'b1) begin
         miscompares++;
         $display("FAIL stream_last: got %08h want 00332313 with tlast", out_data.size() >= 8 ? out_data[7] : 32'hx);
      end
      nlast = 0;
      foreach (out_last[i]) if (out_last[i]) nlast++;
      vectors++;
      if (nlast != 1) begin
         miscompares++;
         $display("FAIL stream_tlast_count: got %0d want 1", nlast);
      end
      check_frame("stream", 0);
   endtask

   task automatic test_stall();
      clear_capture();
      fork
         send_frame();
         begin
            bit seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
               @(posedge clk);
               seen = (out_data.size() >= 1);
            end
            #1;
            m_tready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               vectors++;
               if (s_tready !== 1'b0 || m_tdata !== 32'h00211101 || m_tvalid !== 1'b1) begin
                  miscompares++;
                  $display("FAIL stall_hold[%0d]: got tready=%b valid=%b data=%08h, want 0 1 00211101",
                           i, s_tready, m_tvalid, m_tdata);
               end
               @(posedge clk);
               #1;
            end
            m_tready = 1'b1;
         end
      join
      idle(4);
      vectors++;
      if (out_data.size() != 8) begin
         miscompares++;
         $display("FAIL stall_count: got %0d want 8", out_data.size());
      end
      check_frame("stall", 0);
   endtask

   task automatic test_back_to_back();
      clear_capture();
      send_frame();
      send_frame();
      idle(4);
      vectors++;
      if (out_data.size() != 16) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d want 16", out_data.size());
      end
      vectors++;
      if (out_data.size() < 9 || out_data[8] !== 32'h00201000) begin
         miscompares++;
         $display("FAIL b2b_second_first: got %08h want 00201000", out_data.size() >= 9 ? out_data[8] : 32'hx);
      end
      check_frame("b2b_f0", 0);
      check_frame("b2b_f1", 8);
   endtask

   task automatic test_frame_err();
      clear_capture();
      for (int k = 0; k < W + 2; k++) send_beat(px(k / W, k % W), 1'b0);
      send_beat(px(1, 2), 1'b1);
      vectors++;
      if (frame_err !== 1'b1) begin
         miscompares++;
         $display("FAIL err_pulse: got %b want 1", frame_err);
      end
      idle(1);
      vectors++;
      if (frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear: got %b want 0", frame_err);
      end
      idle(2);
      vectors++;
      if (err_pulses != 1 || out_data.size() != 0) begin
         miscompares++;
         $display("FAIL err_cycles: got %0d pulse cycles, %0d outputs, want 1 and 0", err_pulses, out_data.size());
      end
      send_frame();
      idle(4);
      vectors++;
      if (out_data.size() != 8 || err_pulses != 1) begin
         miscompares++;
         $display("FAIL err_recover_count: got %0d outputs %0d err cycles, want 8 and 1", out_data.size(), err_pulses);
      end
      check_frame("err_recover", 0);
   endtask

   task automatic test_reset_mid();
      clear_capture();
      for (int k = 0; k < 2 * W + 2; k++) send_beat(px(k / W, k % W), 1'b0);
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_col(2, 1)) begin
         miscompares++;
         $display("FAIL pre_reset: got valid=%b data=%08h, want 1 %08h", m_tvalid, m_tdata, exp_col(2, 1));
      end
      s_tvalid = 1'b0;
      rst      = 1'b1;
      #1;
      vectors++;
      if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got valid=%b data=%08h last=%b, want 0 00000000 0", m_tvalid, m_tdata, m_tlast);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      clear_capture();
      send_frame();
      idle(4);
      vectors++;
      if (out_data.size() != 8) begin
         miscompares++;
         $display("FAIL after_reset_count: got %0d want 8", out_data.size());
      end
      check_frame("after_reset", 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      err_pulses = 0;
      test_reset();
      test_stream();
      test_stall();
      test_back_to_back();
      test_frame_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
